serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial, multi-cycle subtractor. Computes DIFF = A - B - BI one bit per clock, LSB first,
//   using a single full-subtractor cell and a borrow flip-flop.
//   It is the subtract-direction counterpart of the 4-bit ripple adder datapath, for area-limited
//   paths that can wait WIDTH cycles. It uses a start/busy/done handshake.
// PARAMETERS
//   WIDTH  4  operand and result width in bits, >= 2
// PORTS
//   clk    in   1      system clock; all state updates on the rising edge
//   rst    in   1      synchronous, active-high reset
//   START  in   1      request; sampled only in IDLE or DONE
//   A      in   WIDTH  minuend; captured on an accepted START
//   B      in   WIDTH  subtrahend; captured on an accepted START
//   BI     in   1      borrow-in; captured on an accepted START
//   BUSY   out  1      high while bits are being processed
//   DONE   out  1      single-cycle pulse; DIFF/BO are valid from this cycle on
//   DIFF   out  WIDTH  difference, modulo 2^WIDTH
//   BO     out  1      borrow-out; 1 when A < B + BI (unsigned)
//   OVF    out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//   Reset (rst=1 at an edge)
//     - state=IDLE; BUSY=0, DONE=0, DIFF=0, BO=0, OVF=0.
//     - The bit counter and shift registers are cleared.
//     - Reset takes priority over everything, including mid-operation; a partial result is discarded.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE / DONE
//     - START=1: capture A, B into shift registers, BI into the borrow FF, count=0; next state SHIFT.
//     - START=0: DONE goes to IDLE; IDLE stays in IDLE.
//   SHIFT (one edge per bit, WIDTH edges in total)
//     - d   = a0 ^ b0 ^ br
//     - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
//     - d is shifted into the result register from the MSB side; A and B shift right by one.
//     - After the edge that processes bit WIDTH-1: DIFF <= result, BO <= br', state <= DONE.
//   Cycle numbering
//     - Cycle n is the cycle in which START=1 is sampled.
//     - BUSY=1 for cycles n+1 .. n+WIDTH.
//     - DONE=1 in cycle n+WIDTH+1 only. Latency is WIDTH+1 clocks.
//   Output timing
//     - DIFF/BO change only on the transition into DONE.
//     - They hold their value until the next completion or reset, so a new START does not disturb them.
//     - During SHIFT, DIFF/BO still show the previous result.
//   START is ignored while in SHIFT; there is no queueing.
//   Back-to-back operation
//     - START=1 in the DONE cycle is accepted.
//     - DONE=0 in the next cycle and BUSY=1 from then on.
//   Boundaries
//     - A==B and BI=0 gives DIFF=0, BO=0.
//     - A=0, B=0, BI=1 gives DIFF = all ones, BO=1.
//   Arithmetic is unsigned; DIFF wraps modulo 2^WIDTH and no widening is done internally.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined
//     - Adds the OVF port.
//     - OVF = (A[MSB] ^ B[MSB]) & (DIFF[MSB] ^ A[MSB]), using the captured operands.
//     - OVF updates together with DIFF and resets to 0.
//   SERIAL_SUB_OVF_EN undefined
//     - No OVF port and no MSB capture logic; everything else is identical.
// TESTING (WIDTH=4)
//   - rst, then A=9, B=3, BI=0, START pulse -> BUSY 4 cycles, DONE at n+5; DIFF=6, BO=0.
//   - A=3, B=9, BI=0 -> DIFF=0xA, BO=1. A=0, B=0, BI=1 -> DIFF=0xF, BO=1.
//   - START (A=7, B=2) with START held high during SHIFT plus A=1, B=1 applied mid-run -> DIFF=5, BO=0;
//     exactly one DONE pulse.
//   - START in the DONE cycle with A=5, B=5 -> second DONE 5 cycles later with DIFF=0, BO=0;
//     DIFF holds the prior value until then.
//   - rst asserted at cycle n+2 of a run -> next cycle BUSY=0, DONE=0, DIFF=0, BO=0;
//     no DONE pulse follows.
//   - SERIAL_SUB_OVF_EN: A=8, B=1 -> DIFF=7, OVF=1. A=5, B=3 -> DIFF=2, OVF=0.
//     Run every case against a reference model: all 512 A/B/BI combinations.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BI, one bit per clock, LSB first, WIDTH+1 clock latency.
// Optional signed-overflow output OVF is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             d_bit;
  logic             br_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Single full-subtractor cell on the current LSBs and the borrow flip-flop.
  always_comb begin
    d_bit   = a_sh[0] ^ b_sh[0] ^ br;
    br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DIFF  <= '0;
      BO    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      OVF   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= BI;
            res   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          // Result fills from the MSB side so bit 0 lands at res[0] after WIDTH shifts.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= {d_bit, res[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            DIFF  <= {d_bit, res[WIDTH-1:1]};
            BO    <= br_next;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            OVF   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=4): directed vectors, handshake timing and an
// exhaustive/randomized comparison against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam logic [7:0] EXP_BUSY = 8'b0001_1110;
  localparam logic [7:0] EXP_DONE = 8'b0010_0000;

  logic         clk;
  logic         rst;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] DIFF;
  logic         BO;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int tests_run;
  int tests_failed;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .A     (A),
    .B     (B),
    .BI    (BI),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DIFF  (DIFF),
    .BO    (BO)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

  // Reference: plain unsigned arithmetic, borrow is the sign bit of a one-bit-wider result.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endfunction

  // Issues one START at the current negedge and records BUSY/DONE for the following cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input logic hold,
                        output logic [7:0] busy_m, output logic [7:0] done_m, output logic held);
    logic [W-1:0] prev;
    prev   = DIFF;
    A      = a;
    B      = b;
    BI     = bi;
    START  = 1'b1;
    busy_m = '0;
    done_m = '0;
    held   = 1'b1;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      busy_m[k] = BUSY;
      done_m[k] = DONE;
      if (k <= W && DIFF !== prev) held = 1'b0;
      START = hold && (k <= W) ? 1'($urandom_range(1)) : 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      BI    = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    BI    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({BUSY, DONE, DIFF, BO} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b, want all 0", BUSY, DONE, DIFF, BO);
    end
`ifdef SERIAL_SUB_OVF_EN
    tests_run++;
    if (OVF !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: got %b want 0", OVF);
    end
`endif
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vbi[5];
    logic [W-1:0] vd [5];
    logic         vbo[5];
    logic [7:0]   bm, dm;
    logic         held;
    va = '{4'd9, 4'd3, 4'd0, 4'd8, 4'd5};
    vb = '{4'd3, 4'd9, 4'd0, 4'd1, 4'd3};
    vbi = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vd = '{4'd6, 4'hA, 4'hF, 4'd7, 4'd2};
    vbo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vbi[i], 1'b0, bm, dm, held);
      tests_run++;
      if (bm !== EXP_BUSY || dm !== EXP_DONE) begin
        tests_failed++;
        $display("FAIL vec%0d_timing: busy=%b done=%b, want busy=%b done=%b", i, bm, dm, EXP_BUSY, EXP_DONE);
      end
      tests_run++;
      if (DIFF !== vd[i] || BO !== vbo[i]) begin
        tests_failed++;
        $display("FAIL vec%0d_result: diff=%h bo=%b, want diff=%h bo=%b", i, DIFF, BO, vd[i], vbo[i]);
      end
`ifdef SERIAL_SUB_OVF_EN
      tests_run++;
      if (i >= 3 && OVF !== (i == 3)) begin
        tests_failed++;
        $display("FAIL vec%0d_ovf: got %b want %b", i, OVF, (i == 3));
      end
`endif
    end
  endtask

  task automatic test_start_held;
    int done_cnt;
    done_cnt = 0;
    A = 4'd7;
    B = 4'd2;
    BI = 1'b0;
    START = 1'b1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (DONE === 1'b1) done_cnt++;
      START = (k <= W);
      A = 4'd1;
      B = 4'd1;
    end
    tests_run++;
    if (done_cnt != 1 || DIFF !== 4'd5 || BO !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_held: dones=%0d diff=%h bo=%b, want dones=1 diff=5 bo=0", done_cnt, DIFF, BO);
    end
  endtask

  task automatic test_mid_reset;
    int done_cnt;
    done_cnt = 0;
    A = 4'd9;
    B = 4'd3;
    BI = 1'b0;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({BUSY, DONE, DIFF, BO} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy=%b done=%b diff=%h bo=%b, want all 0", BUSY, DONE, DIFF, BO);
    end
    rst = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (DONE !== 1'b0 || BUSY !== 1'b0) done_cnt++;
    end
    tests_run++;
    if (done_cnt != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_quiet: %0d cycles with busy/done high, want 0", done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bm, dm;
    logic       held;
    A = 4'd12;
    B = 4'd3;
    BI = 1'b0;
    START = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      START = 1'b0;
    end
    tests_run++;
    if (DONE !== 1'b1 || DIFF !== 4'd9) begin
      tests_failed++;
      $display("FAIL b2b_first: done=%b diff=%h, want done=1 diff=9", DONE, DIFF);
    end
    A = 4'd5;
    B = 4'd5;
    BI = 1'b0;
    START = 1'b1;
    bm = '0;
    dm = '0;
    held = 1'b1;
    for (int m = 1; m <= W + 2; m++) begin
      @(negedge clk);
      START = 1'b0;
      bm[m] = BUSY;
      dm[m] = DONE;
      if (m <= W && DIFF !== 4'd9) held = 1'b0;
    end
    tests_run++;
    if (bm !== EXP_BUSY || dm !== EXP_DONE || held !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second_timing: busy=%b done=%b held=%b, want %b %b 1", bm, dm, held, EXP_BUSY, EXP_DONE);
    end
    tests_run++;
    if (DIFF !== 4'd0 || BO !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_result: diff=%h bo=%b, want 0 0", DIFF, BO);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic hold);
    logic [7:0] bm, dm;
    logic       held;
    logic [W:0] r;
    r = ref_sub(a, b, bi);
    run_op(a, b, bi, hold, bm, dm, held);
    tests_run++;
    if (bm !== EXP_BUSY || dm !== EXP_DONE || held !== 1'b1 || DIFF !== r[W-1:0] || BO !== r[W]) begin
      tests_failed++;
      $display("FAIL %s a=%h b=%h bi=%b: diff=%h bo=%b busy=%b done=%b held=%b, want diff=%h bo=%b busy=%b done=%b held=1",
               name, a, b, bi, DIFF, BO, bm, dm, held, r[W-1:0], r[W], EXP_BUSY, EXP_DONE);
    end
`ifdef SERIAL_SUB_OVF_EN
    tests_run++;
    if (OVF !== ref_ovf(a, b, bi)) begin
      tests_failed++;
      $display("FAIL %s_ovf a=%h b=%h bi=%b: got %b want %b", name, a, b, bi, OVF, ref_ovf(a, b, bi));
    end
`endif
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 512; i++) begin
      check_op("exhaustive", W'(i >> 5), W'(i >> 1), 1'(i), 1'b0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    BI    = 1'b0;
    @(negedge clk);
    test_reset;
    test_vectors;
    test_start_held;
    test_mid_reset;
    test_back_to_back;
    test_exhaustive;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
